// File: rtl/seq_booth_r4_multiplier_pkg.sv
`default_nettype none
// ============================================================================
// Module  : seq_booth_r4_multiplier_pkg
// Purpose : Shared definitions for the sequential radix-4 Booth multiplier:
//           FSM state encodings, one-hot Booth digit codes, and a triplet
//           decoder.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package seq_booth_r4_multiplier_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // One-hot Booth digit code: {NEG, TWO, ONE}. All-zero means digit 0.
    typedef logic [2:0] booth_t;
    localparam booth_t C_BOOTH_ZERO = 3'b000;
    localparam booth_t C_BOOTH_ONE  = 3'b001;
    localparam booth_t C_BOOTH_TWO  = 3'b010;
    localparam booth_t C_BOOTH_NEG  = 3'b100;

    localparam int C_B_ONE = 0;
    localparam int C_B_TWO = 1;
    localparam int C_B_NEG = 2;

    // Triplet {y[2i+1], y[2i], y[2i-1]} -> digit in {0,+1,+1,+2,-2,-1,-1,0}
    function automatic booth_t booth_decode(input logic [2:0] triplet);
        booth_t code;
        code = C_BOOTH_ZERO;
        case (triplet)
            3'b001, 3'b010: code = C_BOOTH_ONE;
            3'b011:         code = C_BOOTH_TWO;
            3'b100:         code = C_BOOTH_NEG | C_BOOTH_TWO;
            3'b101, 3'b110: code = C_BOOTH_NEG | C_BOOTH_ONE;
            default:        code = C_BOOTH_ZERO;
        endcase
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/booth_r4_pp_gen.sv
`default_nettype none
// ============================================================================
// Module  : booth_r4_pp_gen
// Purpose : Combinational radix-4 Booth partial-product generator. Produces
//           digit * xe, sign-extended to 2N+2 bits, before any shifting.
// Ports   : i_triplet  3-bit Booth triplet
//           i_xe       N+2-bit extended multiplicand
//           o_pp       2N+2-bit partial product
// Rev     : 1.0  initial release
// ============================================================================
module booth_r4_pp_gen
    import seq_booth_r4_multiplier_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [2:0]     i_triplet,
    input  logic [N+1:0]   i_xe,
    output logic [2*N+1:0] o_pp
);

    localparam int C_PW = 2 * N + 2;

    booth_t            w_code;
    logic [C_PW-1:0]   w_xs;
    logic [C_PW-1:0]   w_mag;

    assign w_code = booth_decode(i_triplet);
    assign w_xs   = {{N{i_xe[N+1]}}, i_xe};

    always_comb begin
        w_mag = '0;
        if (w_code[C_B_ONE]) begin
            w_mag = w_xs;
        end else if (w_code[C_B_TWO]) begin
            w_mag = w_xs << 1;
        end
    end

    // Negation as invert + 1, modulo 2^(2N+2).
    assign o_pp = w_code[C_B_NEG] ? (~w_mag) + C_PW'(1) : w_mag;

endmodule
`default_nettype wire

// File: rtl/seq_booth_r4_multiplier.sv
`default_nettype none
// ============================================================================
// Module  : seq_booth_r4_multiplier
// Purpose : Sequential radix-4 Booth multiplier, one Booth digit per clock,
//           signed or unsigned per operation, valid/ready on both sides.
// Ports   : clk, rst (async, active-high)
//           in_valid/in_ready   operand handshake; x, y, sgn captured on accept
//           out_valid/out_ready result handshake; z = 2N-bit product
// Rev     : 1.0  initial release
// ============================================================================
module seq_booth_r4_multiplier
    import seq_booth_r4_multiplier_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   x,
    input  logic [N-1:0]   y,
    input  logic           sgn,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] z
);

    localparam int D    = N / 2 + 1;
    localparam int CW   = $clog2(D) + 1;
    localparam int C_AW = 2 * N + 2;

    state_t            r_state;
    state_t            w_state_next;
    logic [N+1:0]      r_xe;
    logic [N+2:0]      r_ye;      // extended y with the implicit 0 at bit 0
    logic [C_AW-1:0]   r_acc;
    logic [CW-1:0]     r_cnt;
    logic [2*N-1:0]    r_z;

    logic [C_AW-1:0]   w_pp;
    logic [CW:0]       w_shamt;
    logic [C_AW-1:0]   w_acc_next;
    logic              w_last;
    logic [1:0]        w_xext;
    logic [1:0]        w_yext;

    booth_r4_pp_gen #(.N(N)) u_pp_gen (
        .i_triplet (r_ye[2:0]),
        .i_xe      (r_xe),
        .o_pp      (w_pp)
    );

    // r_ye is shifted right two bits per digit, so the current triplet
    // always sits at bits [2:0]; the partial product still needs << 2i.
    assign w_shamt    = {r_cnt, 1'b0};
    assign w_acc_next = r_acc + (w_pp << w_shamt);
    assign w_last     = (r_cnt == CW'(D - 1));
    assign w_xext     = sgn ? {2{x[N-1]}} : 2'b00;
    assign w_yext     = sgn ? {2{y[N-1]}} : 2'b00;
    assign z          = r_z;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_xe  <= '0;
            r_ye  <= '0;
            r_acc <= '0;
            r_cnt <= '0;
            r_z   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_xe  <= {w_xext, x};
                        r_ye  <= {w_yext, y, 1'b0};
                        r_acc <= '0;
                        r_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    r_acc <= w_acc_next;
                    r_ye  <= r_ye >> 2;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        // Upper two accumulator bits are never significant.
                        r_z <= w_acc_next[2*N-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_booth_r4_multiplier.sv
`default_nettype none
// ============================================================================
// Module  : tb_seq_booth_r4_multiplier
// Purpose : Self-checking bench for seq_booth_r4_multiplier at N=8 and N=16.
// Ports   : none
// Rev     : 1.0  initial release
// ============================================================================
module tb_seq_booth_r4_multiplier;

    logic        clk;
    logic        rst;

    logic        a_in_valid, a_in_ready, a_sgn, a_out_valid, a_out_ready;
    logic [7:0]  a_x, a_y;
    logic [15:0] a_z;

    logic        b_in_valid, b_in_ready, b_sgn, b_out_valid, b_out_ready;
    logic [15:0] b_x, b_y;
    logic [31:0] b_z;

    int n_checks;
    int n_fail;

    seq_booth_r4_multiplier #(.N(8)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .x         (a_x),
        .y         (a_y),
        .sgn       (a_sgn),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .z         (a_z)
    );

    seq_booth_r4_multiplier #(.N(16)) u_dut16 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .x         (b_x),
        .y         (b_y),
        .sgn       (b_sgn),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .z         (b_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: act=0x%0h exp=0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One N=8 operation with an optional stall before the result is taken.
    task automatic op8(input string tag, input logic [7:0] xa, input logic [7:0] yb,
                       input logic s, input logic [15:0] exp, input int stall);
        int t;
        logic [15:0] zhold;
        t = 0;
        while (!a_in_ready && t < 50) begin tick(); t++; end
        check({tag, "_rdy"}, 64'(a_in_ready), 64'd1);
        a_x = xa; a_y = yb; a_sgn = s; a_in_valid = 1'b1;
        tick();
        // Operands and sgn must not matter after the capture edge.
        a_in_valid = 1'b0; a_sgn = ~s; a_x = ~xa; a_y = ~yb;
        t = 0;
        while (!a_out_valid && t < 20) begin tick(); t++; end
        check({tag, "_lat"}, 64'(t), 64'd5);
        check({tag, "_z"}, 64'(a_z), 64'(exp));
        check({tag, "_inrdy_done"}, 64'(a_in_ready), 64'd0);
        zhold = a_z;
        for (int k = 0; k < stall; k++) begin
            tick();
            check({tag, "_hold_v"}, 64'(a_out_valid), 64'd1);
            check({tag, "_hold_z"}, 64'(a_z), 64'(zhold));
        end
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
        check({tag, "_ov_clr"}, 64'(a_out_valid), 64'd0);
        check({tag, "_z_keep"}, 64'(a_z), 64'(zhold));
    endtask

    task automatic op16(input string tag, input logic [15:0] xa, input logic [15:0] yb,
                        input logic s, input int stall);
        int t;
        logic [31:0] exp;
        logic [31:0] zhold;
        if (s) exp = 32'($signed({{16{xa[15]}}, xa}) * $signed({{16{yb[15]}}, yb}));
        else   exp = {16'd0, xa} * {16'd0, yb};
        t = 0;
        while (!b_in_ready && t < 50) begin tick(); t++; end
        b_x = xa; b_y = yb; b_sgn = s; b_in_valid = 1'b1;
        tick();
        b_in_valid = 1'b0; b_sgn = ~s;
        t = 0;
        while (!b_out_valid && t < 30) begin tick(); t++; end
        check({tag, "_lat"}, 64'(t), 64'd9);
        check({tag, "_z"}, 64'(b_z), 64'(exp));
        zhold = b_z;
        for (int k = 0; k < stall; k++) begin
            tick();
            check({tag, "_hold"}, 64'(b_out_valid), 64'd1);
        end
        check({tag, "_zstable"}, 64'(b_z), 64'(zhold));
        b_out_ready = 1'b1;
        tick();
        b_out_ready = 1'b0;
        check({tag, "_ov_clr"}, 64'(b_out_valid), 64'd0);
    endtask

    initial begin
        logic [15:0] zb;
        logic [15:0] rx, ry;
        logic [7:0]  sx, sy;
        logic [15:0] e8;
        n_checks = 0;
        n_fail   = 0;
        a_in_valid = 0; a_out_ready = 0; a_x = 0; a_y = 0; a_sgn = 0;
        b_in_valid = 0; b_out_ready = 0; b_x = 0; b_y = 0; b_sgn = 0;
        rst = 1'b1;
        #22;
        check("rst_inrdy", 64'(a_in_ready), 64'd1);
        check("rst_ovalid", 64'(a_out_valid), 64'd0);
        check("rst_z", 64'(a_z), 64'd0);
        rst = 1'b0;
        tick();

        op8("neg3x5",   8'hFD, 8'h05, 1'b1, 16'hFFF1, 0);
        op8("u_ffxff",  8'hFF, 8'hFF, 1'b0, 16'hFE01, 0);
        op8("s_ffxff",  8'hFF, 8'hFF, 1'b1, 16'h0001, 0);
        op8("s_80x80",  8'h80, 8'h80, 1'b1, 16'h4000, 0);
        op8("s_80x7f",  8'h80, 8'h7F, 1'b1, 16'hC080, 0);
        op8("u_80x80",  8'h80, 8'h80, 1'b0, 16'h4000, 0);
        op8("s_zero",   8'h00, 8'h9C, 1'b1, 16'h0000, 0);

        // Backpressure: result held, new in_valid ignored while DONE.
        a_x = 8'h0C; a_y = 8'h0B; a_sgn = 1'b0; a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        check("bp_valid", 64'(a_out_valid), 64'd1);
        check("bp_z", 64'(a_z), 64'h0084);
        zb = a_z;
        for (int k = 0; k < 3; k++) begin
            a_x = 8'h03; a_y = 8'h03; a_in_valid = (k == 1);
            tick();
            check("bp_hold_v", 64'(a_out_valid), 64'd1);
            check("bp_hold_z", 64'(a_z), 64'(zb));
            check("bp_inrdy", 64'(a_in_ready), 64'd0);
        end
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
        check("bp_release_v", 64'(a_out_valid), 64'd0);
        check("bp_release_rdy", 64'(a_in_ready), 64'd1);
        tick();
        check("bp_no_capture", 64'(a_in_ready), 64'd1);

        // Asynchronous reset during RUN cycle 2.
        a_x = 8'h55; a_y = 8'h33; a_sgn = 1'b0; a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        check("arst_inrdy", 64'(a_in_ready), 64'd1);
        check("arst_ovalid", 64'(a_out_valid), 64'd0);
        check("arst_z", 64'(a_z), 64'd0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 7; k++) begin
            tick();
            check("arst_no_out", 64'(a_out_valid), 64'd0);
        end
        op8("post_rst", 8'h07, 8'h09, 1'b0, 16'h003F, 1);

        // A few random N=8 operations with stalls.
        for (int i = 0; i < 10; i++) begin
            sx = 8'($urandom);
            sy = 8'($urandom);
            if (i[0]) e8 = 16'($signed({{8{sx[7]}}, sx}) * $signed({{8{sy[7]}}, sy}));
            else      e8 = {8'd0, sx} * {8'd0, sy};
            op8("rnd8", sx, sy, i[0], e8, int'($urandom_range(0, 3)));
        end

        // N=16: corner cases then a random sweep.
        op16("w_s8000", 16'h8000, 16'h8000, 1'b1, 0);
        op16("w_uffff", 16'hFFFF, 16'hFFFF, 1'b0, 2);
        op16("w_s7fff", 16'h7FFF, 16'h8000, 1'b1, 1);
        for (int i = 0; i < 20; i++) begin
            rx = 16'($urandom);
            ry = 16'($urandom);
            op16("rnd16", rx, ry, i[0], int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
